fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage directly upstream of instruction decode. Owns the PC, issues in-order
//   word requests to instruction memory, and buffers returned words with their PC in a small FIFO.
//   Presents {instr, instr_pc} to decode with a valid/ready handshake.
//   Handles branch/jump redirects and stops fetching on decoded halt.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset
//   FIFO_DEPTH  4              instruction buffer entries (power of 2, >=2); also max requests in flight
// PORTS
//   CLK             in   1   clock
//   RST             in   1   asynchronous active-high reset
//   imem_req_valid  out  1   fetch request valid
//   imem_req_addr   out  32  word-aligned fetch address (= PC)
//   imem_req_ready  in   1   memory accepts request this cycle
//   imem_resp_valid in   1   response word valid (in order, >=1 cycle after accept)
//   imem_resp_data  in   32  response instruction word
//   instr_valid     out  1   buffered instruction available to decode
//   instr           out  32  instruction word (word_t)
//   instr_pc        out  32  PC of instr
//   instr_ready     in   1   decode consumes instr this cycle
//   redirect        in   1   branch/jal/jalr resolved taken; flush and refetch
//   redirect_pc     in   32  new PC; bits[1:0] ignored (forced 0)
//   halt            in   1   decode saw HALT; stop fetching
//   halted          out  1   fetch stopped and no requests in flight
// BEHAVIOUR
//   Reset: PC=RESET_PC; FIFO empty; inflight=0; drop=0; halt_q=0; all outputs 0 except imem_req_addr=RESET_PC.
//   Credit rule: imem_req_valid = !halt_q && !halt && !redirect && (inflight + fifo_count < FIFO_DEPTH).
//   Request accept (valid&&ready): PC += 4; inflight++. Address held stable while valid && !ready.
//   Response: inflight-- every imem_resp_valid. If drop>0: word discarded, drop--. Else push {data, pc_q}.
//     pc_q is the head of an internal queue of issued PCs, or equivalently a resp-PC counter advanced by 4.
//   Inflight and FIFO push/pop may all occur in one cycle; counters update by net change.
//   Output: instr_valid = fifo non-empty && !redirect. The pop occurs on instr_valid && instr_ready.
//   The FIFO is first-word-fall-through, so instr/instr_pc show the head entry combinationally.
//   Redirect (1 cycle pulse, priority over everything except RST):
//     - FIFO flushed; PC <= {redirect_pc[31:2], 2'b00}; no request issued this cycle.
//     - drop <= inflight after this cycle's accept/response (responses landing later are discarded).
//     - A response arriving in the redirect cycle is dropped, not pushed.
//   Halt: halt_q set on halt=1, sticky until RST. No new requests. Outstanding responses still fill the FIFO.
//     Redirect alongside or after halt updates PC/flushes but issues nothing.
//     halted = halt_q && inflight==0.
//   Wrap-around: PC wraps 32'hFFFF_FFFC -> 0 silently. FIFO pointers are log2(DEPTH)+1 bits wide (wrap bit).
//   Credit rule guarantees no FIFO overflow. A push with FIFO full is an assertion failure.
//   A response with inflight==0 is also an assertion failure.
//   RST mid-operation: all state cleared immediately. Memory must also be reset; stale responses are not tolerated.
// STRUCTURE
//   datapath_pkg: word_t (existing); add fetch_entry_t {word_t instr; word_t pc;} and constant PC_INCR=4.
//   Sub-module fetch_fifo #(DEPTH, type T=fetch_entry_t): FWFT sync FIFO.
//     Ports: push, pop, flush, full, empty, count, wdata, rdata.
//   Top level holds PC, inflight/drop counters, resp-PC counter, halt_q.
// TESTING
//   1 Stream: ready=1, resp 1 cycle later, instr_ready=1 -> instr_pc 0,4,8,... back-to-back; one instr/cycle after 2-cycle fill.
//   2 Backpressure: instr_ready=0 -> exactly 4 requests issued, then imem_req_valid=0.
//     instr_ready=1 for one cycle -> one new request.
//   3 Redirect with 3 in flight to 0x100 -> 3 responses dropped; next instr_pc=0x100, then 0x104.
//     instr_valid=0 in the redirect cycle.
//   4 Redirect to 0x203 -> imem_req_addr=0x200. Redirect coincident with a response -> that word never reaches decode.
//   5 Halt with 2 in flight -> no further requests; both words delivered; halted=1 once inflight=0; stays 1.
//   6 RST asserted mid-stream (async, between edges) -> outputs 0 immediately; after release first addr=RESET_PC.
//     PC 0xFFFF_FFFC -> next addr 0x0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath types for the front end: machine word, fetch buffer entry, PC step.
package datapath_pkg;
    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

    localparam word_t PC_INCR = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through sync FIFO holding fetched words with their PCs.
// Latency: a push is visible at rdata the next cycle. Flush empties it in one cycle.
import datapath_pkg::*;

module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  T                         wdata,
    output T                         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rdata = empty ? T'('0) : mem[rd_ptr[AW-1:0]];

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch: owns the PC, issues word requests under a credit limit,
// buffers responses with their PCs, handles redirects (flush + drop stale words) and halt.
import datapath_pkg::*;

module fetch_unit #(
    parameter word_t RESET_PC   = 32'h0000_0000,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    word_t          pc;
    word_t          resp_pc;
    word_t          target;
    logic [CW-1:0]  inflight;
    logic [CW-1:0]  inflight_nxt;
    logic [CW-1:0]  drop;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    used;
    logic           halt_q;
    logic           accept;
    logic           push;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    fetch_entry_t   wentry;
    fetch_entry_t   rentry;

    assign target = {redirect_pc[31:2], 2'b00};
    assign used   = {1'b0, inflight} + {1'b0, fifo_count};

    // Outstanding requests plus buffered words never exceed the buffer size.
    assign imem_req_valid = !rst && !halt_q && !halt && !redirect
                            && (used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign push   = imem_resp_valid && (drop == '0) && !redirect;
    assign wentry = '{instr: imem_resp_data, pc: resp_pc};

    assign instr_valid = !fifo_empty && !redirect;
    assign pop         = instr_valid && instr_ready;
    assign instr       = rentry.instr;
    assign instr_pc    = rentry.pc;
    assign halted      = halt_q && (inflight == '0);

    assign inflight_nxt = inflight + CW'(accept) - CW'(imem_resp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            halt_q   <= 1'b0;
        end else begin
            inflight <= inflight_nxt;
            if (halt) halt_q <= 1'b1;
            if (redirect) begin
                // Everything still outstanding after this cycle belongs to the old path.
                pc      <= target;
                resp_pc <= target;
                drop    <= inflight_nxt;
            end else begin
                if (accept) pc <= pc + PC_INCR;
                if (push) resp_pc <= resp_pc + PC_INCR;
                if (imem_resp_valid && (drop != '0)) drop <= drop - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (wentry),
        .rdata (rentry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    a_resp_expected: assert property (@(posedge clk) disable iff (rst)
                                      imem_resp_valid |-> (inflight != '0));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: hand vectors for stream/backpressure, directed corner sequences,
// and randomized traffic against an epoch-tagged memory and delivery model.
import datapath_pkg::*;

module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        halted;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        word_t addr;
        int    epoch;
        int    due;
    } pend_t;

    typedef struct {
        bit    ir;
        bit    e_rv;
        word_t e_addr;
        bit    e_iv;
        word_t e_pc;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           lat = 1;
    int           m_epoch = 0;
    bit           m_halt = 0;
    word_t        m_pc = 32'h0;
    pend_t        pend[$];
    fetch_entry_t mq[$];
    word_t        got[$];
    bit           s_rv;
    bit           s_iv;
    word_t        s_addr;
    word_t        s_pc;
    vec_t         vecs[15];

    function automatic word_t memword(word_t a);
        return (a * 32'd2654435761) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, check after settling, advance the model, clock.
    task automatic cycle(input bit rdy, input bit ir, input bit rd, input word_t rpc, input bit hl);
        bit    exp_rv;
        bit    exp_iv;
        bit    rsp;
        pend_t e;
        imem_req_ready = rdy;
        instr_ready    = ir;
        redirect       = rd;
        redirect_pc    = rpc;
        halt           = hl;
        rsp = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_resp_valid = rsp;
        imem_resp_data  = rsp ? memword(pend[0].addr) : $urandom;
        #1;
        exp_rv = !m_halt && !hl && !rd && ((pend.size() + mq.size()) < 4);
        exp_iv = (mq.size() > 0) && !rd;
        s_rv = imem_req_valid; s_iv = instr_valid; s_addr = imem_req_addr; s_pc = instr_pc;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
        if (exp_iv) begin
            chk("instr", instr, mq[0].instr);
            chk("instr_pc", instr_pc, mq[0].pc);
        end
        chk("halted", 32'(halted), 32'(m_halt && (pend.size() == 0)));
        if (exp_iv && ir) begin
            got.push_back(mq[0].pc);
            void'(mq.pop_front());
        end
        if (rsp) begin
            e = pend.pop_front();
            if (!rd && e.epoch == m_epoch) mq.push_back('{instr: memword(e.addr), pc: e.addr});
        end
        if (rd) begin
            mq.delete();
            got.delete();
            m_epoch++;
            m_pc = {rpc[31:2], 2'b00};
        end else if (exp_rv && rdy) begin
            pend.push_back('{addr: m_pc, epoch: m_epoch, due: cyc + lat});
            m_pc = m_pc + 32'd4;
        end
        if (hl) m_halt = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_instr_pc"}, instr_pc, 32'h0);
        chk({tag, "_halted"}, 32'(halted), 32'h0);
    endtask

    // Asserted between edges; memory is reset alongside the DUT.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        imem_resp_valid = 1'b0;
        #1 check_reset_outputs(tag);
        pend.delete(); mq.delete(); got.delete();
        m_pc = 32'h0; m_halt = 1'b0; m_epoch++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((pend.size() > 0 || mq.size() > 0) && n < 60) begin
            cycle(0, 1, 0, 0, 0);
            n++;
        end
        chk("drain_done", 32'(pend.size() + mq.size()), 32'h0);
        got.delete();
    endtask

    initial begin
        #3 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Stream then backpressure, expectations hand-derived for 1-cycle memory latency.
        for (int n = 0; n < 6; n++)
            vecs[n] = '{ir: 1, e_rv: 1, e_addr: 32'(4*n), e_iv: (n >= 2), e_pc: 32'(4*(n-2))};
        vecs[6]  = '{0, 1, 32'd24, 1, 32'd16};
        vecs[7]  = '{0, 1, 32'd28, 1, 32'd16};
        vecs[8]  = '{0, 0, 32'd0,  1, 32'd16};
        vecs[9]  = '{0, 0, 32'd0,  1, 32'd16};
        vecs[10] = '{0, 0, 32'd0,  1, 32'd16};
        vecs[11] = '{1, 0, 32'd0,  1, 32'd16};
        vecs[12] = '{0, 1, 32'd32, 1, 32'd20};
        vecs[13] = '{0, 0, 32'd0,  1, 32'd20};
        vecs[14] = '{0, 0, 32'd0,  1, 32'd20};
        lat = 1;
        for (int i = 0; i < 15; i++) begin
            cycle(1, vecs[i].ir, 0, 0, 0);
            chk($sformatf("vec%0d_rv", i), 32'(s_rv), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv) chk($sformatf("vec%0d_addr", i), s_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_iv", i), 32'(s_iv), 32'(vecs[i].e_iv));
            if (vecs[i].e_iv) chk($sformatf("vec%0d_pc", i), s_pc, vecs[i].e_pc);
        end
        drain();

        // Redirect with three requests in flight and a word buffered.
        lat = 1; cycle(1, 0, 0, 0, 0);
        lat = 8;
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 1, 32'h100, 0);
        chk("redir_cycle_iv", 32'(s_iv), 32'h0);
        lat = 1;
        for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0, 0);
        chk("redir_delivered", 32'(got.size() >= 2), 32'h1);
        if (got.size() >= 2) begin
            chk("redir_pc0", got[0], 32'h100);
            chk("redir_pc1", got[1], 32'h104);
        end
        drain();

        // Misaligned target, then redirect coincident with a response.
        cycle(0, 1, 1, 32'h203, 0);
        cycle(0, 1, 0, 0, 0);
        chk("align_addr", s_addr, 32'h200);
        chk("align_rv", 32'(s_rv), 32'h1);
        drain();
        lat = 2;
        cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 32'h300, 0);
        lat = 1;
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, 0);
        chk("coinc_delivered", 32'(got.size() >= 1), 32'h1);
        if (got.size() >= 1) chk("coinc_first_pc", got[0], 32'h300);
        drain();

        // Halt with two in flight.
        lat = 4;
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 1);
        chk("halt_rv", 32'(s_rv), 32'h0);
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 0);
        chk("halt_halted", 32'(halted), 32'h1);
        chk("halt_words", 32'(got.size()), 32'h2);
        cycle(1, 1, 1, 32'h40, 0);
        cycle(1, 1, 0, 0, 0);
        chk("halt_redir_rv", 32'(s_rv), 32'h0);

        // Reset mid-stream.
        async_reset("rst1");
        lat = 1;
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 0);
        async_reset("rst2");
        cycle(1, 1, 0, 0, 0);
        chk("post_rst_rv", 32'(s_rv), 32'h1);
        chk("post_rst_addr", s_addr, 32'h0);
        drain();

        // PC wrap.
        cycle(0, 1, 1, 32'hFFFF_FFFC, 0);
        cycle(1, 1, 0, 0, 0);
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        cycle(1, 1, 0, 0, 0);
        chk("wrap_addr1", s_addr, 32'h0);
        drain();

        // Randomized traffic, reset between phases to clear sticky halt.
        for (int ph = 0; ph < 4; ph++) begin
            async_reset("rphase");
            for (int i = 0; i < 600; i++) begin
                lat = $urandom_range(1, 4);
                cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                      ($urandom_range(0, 19) == 0), $urandom,
                      ($urandom_range(0, 399) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
